// File: rtl/matrix_key_emulator_if.sv
// Command port of the 4x4 keypad emulator: one key press/release event per handshake.
// A command transfers on a clock edge where cmd_valid and cmd_ready are both high; the requester holds cmd_valid, cmd_key and cmd_press stable until then.
interface matrix_key_emulator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic       cmd_press;

  modport master (output cmd_valid, output cmd_key, output cmd_press, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_press, output cmd_ready);
endinterface

// File: rtl/matrix_key_emulator.sv
// Keypad-side responder for a 4x4 active-low matrix scanner. It replays key press/release
// commands on the col lines, with LFSR-driven contact bounce on the key that is changing.
module matrix_key_emulator #(
  parameter int          BOUNCE_CYC  = 60000,
  parameter int          BOUNCE_STEP = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            row,
  output logic [3:0]            col,
  matrix_key_emulator_if.slave  cmd,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           key_state,
  output logic [1:0]            fsm_state
);

  localparam int CW = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam int SW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
  localparam logic [SW-1:0] STEP_LAST = SW'((BOUNCE_STEP > 0) ? BOUNCE_STEP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          started;
  logic [15:0]   key_nx;
  logic [3:0]    tgt, tgt_nx;
  logic          tgt_val, tgt_val_nx;
  logic          level, level_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] step_cnt, step_nx;
  logic [15:0]   lfsr, lfsr_nx;
  logic          lfsr_fb;
  logic [15:0]   eff;
  logic [3:0]    col_nx;
  logic          accept;

  // Ready is held low while in reset and only rises on the first edge after release.
  assign cmd.cmd_ready = started && (state == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state == BOUNCE);
  assign done          = (state == DONE);
  assign fsm_state     = state;
  assign lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      started   <= 1'b0;
      key_state <= 16'h0000;
      tgt       <= 4'd0;
      tgt_val   <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      step_cnt  <= '0;
      lfsr      <= LFSR_SEED;
      col       <= 4'hF;
    end else begin
      state     <= state_nx;
      started   <= 1'b1;
      key_state <= key_nx;
      tgt       <= tgt_nx;
      tgt_val   <= tgt_val_nx;
      level     <= level_nx;
      cnt       <= cnt_nx;
      step_cnt  <= step_nx;
      lfsr      <= lfsr_nx;
      col       <= col_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    key_nx     = key_state;
    tgt_nx     = tgt;
    tgt_val_nx = tgt_val;
    level_nx   = level;
    cnt_nx     = cnt;
    step_nx    = step_cnt;
    lfsr_nx    = lfsr;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_press == key_state[cmd.cmd_key]) begin
            state_nx = DONE;
          end else if (BOUNCE_CYC == 0) begin
            key_nx[cmd.cmd_key] = cmd.cmd_press;
            state_nx            = DONE;
          end else begin
            // The bouncing contact starts from its old level so the window opens without a glitch.
            tgt_nx     = cmd.cmd_key;
            tgt_val_nx = cmd.cmd_press;
            level_nx   = ~cmd.cmd_press;
            cnt_nx     = '0;
            step_nx    = '0;
            state_nx   = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        if (cnt == CNT_LAST) begin
          key_nx[tgt] = tgt_val;
          state_nx    = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
          if (step_cnt == STEP_LAST) begin
            step_nx  = '0;
            lfsr_nx  = {lfsr[14:0], lfsr_fb};
            level_nx = lfsr_fb;
          end else begin
            step_nx = step_cnt + 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Contact matrix: a closed key pulls its column low whenever its row is driven low.
  always_comb begin
    eff = key_state;
    if (state == BOUNCE) eff[tgt] = level;
    col_nx = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (eff[4*r+c] && !row[r]) col_nx[c] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_key_emulator.sv
// Bench for matrix_key_emulator: an instance without bounce and one with a short bounce window,
// sharing one clock; key_state is scoreboarded on every done pulse.
module tb_matrix_key_emulator;
  localparam int S_CYC  = 2000;
  localparam int S_STEP = 64;

  logic        clk;
  logic        rst_n_f, rst_n_s;
  logic [3:0]  row_f, row_s, col_f, col_s;
  logic        busy_f, busy_s, done_f, done_s;
  logic [15:0] key_state_f, key_state_s;
  logic [1:0]  fsm_f, fsm_s;

  matrix_key_emulator_if if_f ();
  matrix_key_emulator_if if_s ();

  matrix_key_emulator #(.BOUNCE_CYC(0), .BOUNCE_STEP(256), .LFSR_SEED(16'hACE1)) dut_f (
    .clk(clk), .rst_n(rst_n_f), .row(row_f), .col(col_f), .cmd(if_f),
    .busy(busy_f), .done(done_f), .key_state(key_state_f), .fsm_state(fsm_f)
  );

  matrix_key_emulator #(.BOUNCE_CYC(S_CYC), .BOUNCE_STEP(S_STEP), .LFSR_SEED(16'hACE1)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .row(row_s), .col(col_s), .cmd(if_s),
    .busy(busy_s), .done(done_s), .key_state(key_state_s), .fsm_state(fsm_s)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected key_state pushed per command, popped on done
  logic [15:0] exp_q_f[$];
  logic [15:0] exp_q_s[$];
  logic [15:0] model_f = 16'h0;
  logic [15:0] model_s = 16'h0;

  int bcnt = 0, cyc_s = 0, hs_cyc = -1, done_cyc = -1, toggles = 0, rec_mode = 0;
  logic prev_c0 = 1'b1;
  bit pat0 [S_CYC];
  bit pat1 [S_CYC];

  always @(negedge clk) begin
    if (rst_n_f && done_f) begin
      if (exp_q_f.size() == 0) check("sb_f_unexpected_done", 32'(exp_q_f.size()), 1);
      else check("sb_f_key_state", key_state_f, exp_q_f.pop_front());
    end
  end

  always @(negedge clk) begin
    cyc_s++;
    if (!rst_n_s) begin
      bcnt = 0;
    end else begin
      if (done_s) begin
        done_cyc = cyc_s;
        if (exp_q_s.size() == 0) check("sb_s_unexpected_done", 32'(exp_q_s.size()), 1);
        else check("sb_s_key_state", key_state_s, exp_q_s.pop_front());
      end
      if (if_s.cmd_valid && if_s.cmd_ready) hs_cyc = cyc_s;
      if (busy_s) begin
        // col lags the bounce level by one register, so changes land one cycle after a step
        if (bcnt > 0 && col_s[0] !== prev_c0) begin
          toggles++;
          check("bounce_on_step", (bcnt - 1) % S_STEP, 0);
        end
        if (bcnt < S_CYC) begin
          if (rec_mode == 1) pat0[bcnt] = col_s[0];
          else if (rec_mode == 2) pat1[bcnt] = col_s[0];
        end
        bcnt++;
      end else if (bcnt > 0) begin
        check("busy_len", bcnt, S_CYC);
        bcnt = 0;
      end
    end
    prev_c0 = col_s[0];
  end

  // Driver tasks
  task automatic send(input bit slow, input logic [3:0] key, input bit press);
    int g = 0;
    if (slow) begin
      model_s[key] = press;
      exp_q_s.push_back(model_s);
      if_s.cmd_key = key; if_s.cmd_press = press; if_s.cmd_valid = 1'b1;
    end else begin
      model_f[key] = press;
      exp_q_f.push_back(model_f);
      if_f.cmd_key = key; if_f.cmd_press = press; if_f.cmd_valid = 1'b1;
    end
    while (!(slow ? if_s.cmd_ready : if_f.cmd_ready) && g < 3 * S_CYC) begin
      @(negedge clk);
      g++;
    end
    check("handshake_seen", 32'(g < 3 * S_CYC), 1);
    @(posedge clk);
    #1;
    if (slow) if_s.cmd_valid = 1'b0;
    else if_f.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit slow, input int limit);
    int g = 0;
    while (!(slow ? done_s : done_f) && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", 32'(g < limit), 1);
  endtask

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int mism;
    logic [3:0] r, exp_col;
    vecs[0] = '{4'b1111, 4'b1111};
    vecs[1] = '{4'b1110, 4'b1110};
    vecs[2] = '{4'b1101, 4'b1101};
    vecs[3] = '{4'b1011, 4'b1011};
    vecs[4] = '{4'b0111, 4'b0111};
    vecs[5] = '{4'b0000, 4'b0000};
    vecs[6] = '{4'b1100, 4'b1100};
    vecs[7] = '{4'b0110, 4'b0110};

    rst_n_f = 1'b0; rst_n_s = 1'b0;
    row_f = 4'b1110; row_s = 4'b1110;
    if_f.cmd_valid = 1'b0; if_f.cmd_key = 4'd0; if_f.cmd_press = 1'b0;
    if_s.cmd_valid = 1'b0; if_s.cmd_key = 4'd0; if_s.cmd_press = 1'b0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_col_f", col_f, 4'hF);
    check("rst_key_state_f", key_state_f, 16'h0);
    check("rst_busy_f", busy_f, 0);
    check("rst_done_f", done_f, 0);
    check("rst_col_s", col_s, 4'hF);
    rst_n_f = 1'b1; rst_n_s = 1'b1;
    @(negedge clk);
    check("ready_after_rst_f", if_f.cmd_ready, 1);
    check("ready_after_rst_s", if_s.cmd_ready, 1);

    // 2: no-bounce press of key 6, then col latency
    send(0, 4'd6, 1'b1);
    @(negedge clk);
    check("nb_done", done_f, 1);
    check("nb_busy", busy_f, 0);
    check("nb_key_state", key_state_f, 16'h0040);
    @(negedge clk);
    check("nb_done_one_cycle", done_f, 0);
    row_f = 4'b1101;
    #1 check("col_latency_hold", col_f, 4'hF);
    @(negedge clk);
    check("col_key6", col_f, 4'b1011);
    row_f = 4'b1110;
    @(negedge clk);
    check("col_row0_key6", col_f, 4'hF);

    // 4: diagonal keys, table-driven then random rows against the contact model
    send(0, 4'd6, 1'b0);
    send(0, 4'd0, 1'b1);
    send(0, 4'd5, 1'b1);
    send(0, 4'd10, 1'b1);
    send(0, 4'd15, 1'b1);
    repeat (2) @(negedge clk);
    check("diag_key_state", key_state_f, 16'h8421);
    for (int i = 0; i < 8; i++) begin
      row_f = vecs[i].row;
      @(negedge clk);
      check($sformatf("vec%0d_col", i), col_f, vecs[i].col);
    end
    send(0, 4'd9, 1'b1);
    for (int i = 0; i < 12; i++) begin
      r = 4'($urandom_range(0, 15));
      row_f = r;
      @(negedge clk);
      exp_col = 4'hF;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          if (model_f[4*rr+c] && !r[rr]) exp_col[c] = 1'b0;
      check($sformatf("rand_row_%b_col", r), col_f, exp_col);
    end
    send(0, 4'd5, 1'b1);
    @(negedge clk);
    check("noop_done", done_f, 1);
    check("noop_busy", busy_f, 0);
    check("noop_key_state", key_state_f, 16'h8621);

    // 3: bounced press and release of key 0, row 0 selected
    rec_mode = 1;
    send(1, 4'd0, 1'b1);
    @(negedge clk);
    check("bounce_busy", busy_s, 1);
    check("bounce_ready_low", if_s.cmd_ready, 0);
    wait_done(1, S_CYC + 10);
    rec_mode = 0;
    check("bounce_toggled", 32'(toggles > 0), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("settled_press_col", col_s, 4'b1110);
    end
    send(1, 4'd0, 1'b1);
    @(negedge clk);
    check("noop_s_done", done_s, 1);
    check("noop_s_busy", busy_s, 0);
    send(1, 4'd0, 1'b0);
    wait_done(1, S_CYC + 10);
    repeat (2) @(negedge clk);
    check("settled_release_col", col_s, 4'hF);

    // 5: back-to-back, key 3 held off during key 12 bounce
    send(1, 4'd12, 1'b1);
    send(1, 4'd3, 1'b1);
    check("b2b_accept_after_done", hs_cyc, done_cyc + 1);
    wait_done(1, S_CYC + 10);
    repeat (2) @(negedge clk);
    check("b2b_key_state", key_state_s, 16'h1008);
    check("b2b_queue_empty", exp_q_s.size(), 0);

    // 6: reset mid-bounce and replay from seed
    rst_n_s = 1'b0;
    model_s = 16'h0;
    exp_q_s.delete();
    @(negedge clk);
    rst_n_s = 1'b1;
    @(negedge clk);
    rec_mode = 2;
    send(1, 4'd0, 1'b1);
    repeat (1000) @(negedge clk);
    rst_n_s = 1'b0;
    model_s = 16'h0;
    exp_q_s.delete();
    #1;
    check("midrst_col", col_s, 4'hF);
    check("midrst_key_state", key_state_s, 16'h0);
    check("midrst_busy", busy_s, 0);
    rec_mode = 0;
    mism = 0;
    for (int i = 0; i < 990; i++) if (pat0[i] != pat1[i]) mism++;
    check("lfsr_replay_mismatches", mism, 0);
    @(negedge clk);
    rst_n_s = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_key_state_after", key_state_s, 16'h0);
    check("midrst_ready_after", if_s.cmd_ready, 1);

    check("final_queue_f", exp_q_f.size(), 0);
    check("final_queue_s", exp_q_s.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
